// File: rtl/axi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  axi_mem_responder_pkg : shared types and constants for axi_mem_responder
//  Revision : 1.0
// ============================================================================
package axi_mem_responder_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_BURST = 1'b1
   } rd_state_t;

   localparam int ERR_ARSIZE = 0;
   localparam int ERR_WLAST  = 1;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_responder_ram.sv
`default_nettype none
// ============================================================================
//  axi_mem_responder_ram : simple dual-port RAM, byte-enabled write port,
//  1-cycle registered read-first read port
//  Revision : 1.0
// ============================================================================
module axi_mem_responder_ram #(
   parameter int DATA_W = 512,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
) (
   input  logic                clk,
   input  logic                i_we,
   input  logic [IDX_W-1:0]    i_waddr,
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_wstrb,
   input  logic                i_re,
   input  logic [IDX_W-1:0]    i_raddr,
   output logic [DATA_W-1:0]   o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Both ports update with non-blocking assignments, so a colliding read sees old data
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  axi_mem_responder : AXI4 slave serving INCR bursts from on-chip RAM
//  Revision : 1.0
// ============================================================================
module axi_mem_responder
   import axi_mem_responder_pkg::*;
#(
   parameter int C_S_AXI_ID_WIDTH   = 1,
   parameter int C_S_AXI_ADDR_WIDTH = 64,
   parameter int C_S_AXI_DATA_WIDTH = 512,
   parameter int C_MEM_DEPTH        = 1024
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic                            s00_axi_awvalid,
   output logic                            s00_axi_awready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
   input  logic [7:0]                      s00_axi_awlen,
   input  logic                            s00_axi_wvalid,
   output logic                            s00_axi_wready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
   input  logic                            s00_axi_wlast,
   output logic                            s00_axi_bvalid,
   input  logic                            s00_axi_bready,
   input  logic                            s00_axi_arvalid,
   output logic                            s00_axi_arready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
   input  logic [7:0]                      s00_axi_arlen,
   input  logic [2:0]                      s00_axi_arsize,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_arid,
   output logic                            s00_axi_rvalid,
   input  logic                            s00_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
   output logic                            s00_axi_rlast,
   output logic [C_S_AXI_ID_WIDTH-1:0]     s00_axi_rid,
   output logic [1:0]                      err_flags
);

   localparam int                c_addr_lsb = addr_lsb(C_S_AXI_DATA_WIDTH);
   localparam int                c_idx_w    = idx_w(C_MEM_DEPTH);
   localparam logic [2:0]        c_arsize   = 3'(c_addr_lsb);
   localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);

   // ---------------- write channel ----------------
   wr_state_t                 r_wr_state;
   logic [c_idx_w-1:0]        r_wr_idx;
   logic [7:0]                r_wr_len;
   logic [7:0]                r_wr_beat;
   logic                      r_err_wlast;
   logic                      w_wr_fire;
   logic                      w_wr_final;

   assign w_wr_fire  = s00_axi_wvalid & s00_axi_wready;
   assign w_wr_final = (r_wr_beat == r_wr_len);

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_wr_state      <= W_IDLE;
         s00_axi_awready <= 1'b0;
         s00_axi_wready  <= 1'b0;
         s00_axi_bvalid  <= 1'b0;
         r_err_wlast     <= 1'b0;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               s00_axi_awready <= 1'b1;
               if (s00_axi_awvalid && s00_axi_awready) begin
                  r_wr_idx        <= s00_axi_awaddr[c_addr_lsb +: c_idx_w];
                  r_wr_len        <= s00_axi_awlen;
                  r_wr_beat       <= 8'd0;
                  s00_axi_awready <= 1'b0;
                  s00_axi_wready  <= 1'b1;
                  r_wr_state      <= W_DATA;
               end
            end
            W_DATA: begin
               // Beat count alone ends the burst; wlast is only audited
               if (w_wr_fire) begin
                  r_wr_idx  <= r_wr_idx + c_idx_one;
                  r_wr_beat <= r_wr_beat + 8'd1;
                  if (s00_axi_wlast != w_wr_final) begin
                     r_err_wlast <= 1'b1;
                  end
                  if (w_wr_final) begin
                     s00_axi_wready <= 1'b0;
                     s00_axi_bvalid <= 1'b1;
                     r_wr_state     <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s00_axi_bready) begin
                  s00_axi_bvalid  <= 1'b0;
                  s00_axi_awready <= 1'b1;
                  r_wr_state      <= W_IDLE;
               end
            end
            default: r_wr_state <= W_IDLE;
         endcase
      end
   end

   // ---------------- read channel ----------------
   rd_state_t                        r_rd_state;
   logic [c_idx_w-1:0]               r_rd_idx;
   logic [7:0]                       r_rd_len;
   logic [8:0]                       r_iss_cnt;
   logic                             r_infl;
   logic                             r_infl_last;
   logic [1:0]                       r_count;
   logic [C_S_AXI_DATA_WIDTH-1:0]    r_head_data;
   logic                             r_head_last;
   logic [C_S_AXI_DATA_WIDTH-1:0]    r_skid_data;
   logic                             r_skid_last;
   logic                             r_err_arsize;
   logic [C_S_AXI_DATA_WIDTH-1:0]    w_ram_rdata;
   logic                             w_pop;
   logic                             w_issue;
   logic                             w_issue_last;
   logic [2:0]                       w_occ;

   assign w_pop        = (r_count != 2'd0) & s00_axi_rready;
   // Count the slot freed by this cycle's pop so rready=1 streams without bubbles
   assign w_occ        = {1'b0, r_count} + {2'b00, r_infl} - {2'b00, w_pop};
   assign w_issue      = (r_rd_state == R_BURST) && (r_iss_cnt <= {1'b0, r_rd_len})
                         && (w_occ < 3'd2);
   assign w_issue_last = (r_iss_cnt == {1'b0, r_rd_len});

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_rd_state      <= R_IDLE;
         s00_axi_arready <= 1'b0;
         r_infl          <= 1'b0;
         r_count         <= 2'd0;
         r_err_arsize    <= 1'b0;
      end else begin
         r_infl      <= w_issue;
         r_infl_last <= w_issue_last;
         r_count     <= r_count + {1'b0, r_infl} - {1'b0, w_pop};
         if (w_issue) begin
            r_rd_idx  <= r_rd_idx + c_idx_one;
            r_iss_cnt <= r_iss_cnt + 9'd1;
         end
         case (r_rd_state)
            R_IDLE: begin
               s00_axi_arready <= (r_count == 2'd0) && !r_infl;
               if (s00_axi_arvalid && s00_axi_arready) begin
                  r_rd_idx        <= s00_axi_araddr[c_addr_lsb +: c_idx_w];
                  r_rd_len        <= s00_axi_arlen;
                  r_iss_cnt       <= 9'd0;
                  s00_axi_rid     <= s00_axi_arid;
                  s00_axi_arready <= 1'b0;
                  r_rd_state      <= R_BURST;
                  if (s00_axi_arsize != c_arsize) begin
                     r_err_arsize <= 1'b1;
                  end
               end
            end
            R_BURST: begin
               if (w_pop && r_head_last) begin
                  s00_axi_arready <= 1'b1;
                  r_rd_state      <= R_IDLE;
               end
            end
            default: r_rd_state <= R_IDLE;
         endcase
      end
   end

   // Head/skid output buffer; data is left untouched through reset
   always_ff @(posedge ap_clk) begin
      if (ap_rst_n) begin
         if (w_pop) begin
            if (r_count == 2'd2) begin
               r_head_data <= r_skid_data;
               r_head_last <= r_skid_last;
            end else if (r_infl) begin
               r_head_data <= w_ram_rdata;
               r_head_last <= r_infl_last;
            end
         end else if (r_infl) begin
            if (r_count == 2'd0) begin
               r_head_data <= w_ram_rdata;
               r_head_last <= r_infl_last;
            end else begin
               r_skid_data <= w_ram_rdata;
               r_skid_last <= r_infl_last;
            end
         end
      end
   end

   assign s00_axi_rvalid = (r_count != 2'd0);
   assign s00_axi_rdata  = r_head_data;
   assign s00_axi_rlast  = s00_axi_rvalid & r_head_last;

   always_comb begin
      err_flags             = 2'b00;
      err_flags[ERR_ARSIZE] = r_err_arsize;
      err_flags[ERR_WLAST]  = r_err_wlast;
   end

   logic w_unused_addr;
   assign w_unused_addr = ^{s00_axi_awaddr, s00_axi_araddr};

   axi_mem_responder_ram #(
      .DATA_W (C_S_AXI_DATA_WIDTH),
      .DEPTH  (C_MEM_DEPTH),
      .IDX_W  (c_idx_w)
   ) u_ram (
      .clk     (ap_clk),
      .i_we    (w_wr_fire),
      .i_waddr (r_wr_idx),
      .i_wdata (s00_axi_wdata),
      .i_wstrb (s00_axi_wstrb),
      .i_re    (w_issue),
      .i_raddr (r_rd_idx),
      .o_rdata (w_ram_rdata)
   );

endmodule
`default_nettype wire
